// File: rtl/synarray_row_reader.sv
// Synapse-array row reader: fetches one pre-neuron row from SRAM and
// streams its mapped 4-bit synapse lanes as post-neuron beats.
module synarray_row_reader #(
  parameter bit SKIP_UNMAPPED = 1'b1,
  parameter int WORDS_PER_ROW = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SPI_GATE_ACTIVITY_sync,
  input  logic        EVT_VALID,
  input  logic [9:0]  EVT_PRE_ADDR,
  output logic        EVT_READY,
  output logic        SYNARRAY_CS,
  output logic        SYNARRAY_WE,
  output logic [12:0] SYNARRAY_ADDR,
  input  logic [31:0] SYNARRAY_RDATA,
  output logic        SYN_VALID,
  input  logic        SYN_READY,
  output logic [9:0]  SYN_PRE_ADDR,
  output logic [5:0]  SYN_POST_ADDR,
  output logic [2:0]  SYN_WEIGHT,
  output logic        ROW_DONE,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    UNPACK,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [9:0]  pre_q;
  logic [2:0]  widx_q;
  logic [2:0]  lane_q;
  logic [31:0] word_q;
  logic [3:0]  nib;
  logic        beat;
  logic        last_word;
  logic        last_lane;
  logic        rdy;
  logic        cs;
  logic        vld;
  logic        adv;
  logic        done;

  assign nib       = word_q[{lane_q, 2'b00} +: 4];
  assign beat      = nib[3] | ~SKIP_UNMAPPED;
  assign last_word = (widx_q == 3'(WORDS_PER_ROW - 1));
  assign last_lane = (lane_q == 3'd7);

  always_comb begin
    state_nx = state;
    rdy      = 1'b0;
    cs       = 1'b0;
    vld      = 1'b0;
    adv      = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = ~SPI_GATE_ACTIVITY_sync;
        if (EVT_VALID && rdy) state_nx = READ;
      end
      READ: begin
        cs       = 1'b1;
        state_nx = WAIT;
      end
      WAIT: state_nx = UNPACK;
      UNPACK: begin
        vld = beat;
        // Suppressed lanes advance without a handshake.
        adv = ~beat | SYN_READY;
        if (adv && last_lane) state_nx = last_word ? DONE : READ;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      pre_q  <= '0;
      widx_q <= '0;
      lane_q <= '0;
      word_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && EVT_VALID && rdy) begin
        pre_q  <= EVT_PRE_ADDR;
        widx_q <= '0;
        lane_q <= '0;
      end
      if (state == WAIT) word_q <= SYNARRAY_RDATA;
      if (adv) begin
        lane_q <= lane_q + 3'd1;
        if (last_lane && !last_word) widx_q <= widx_q + 3'd1;
      end
    end
  end

  assign EVT_READY     = rdy & ~RST;
  assign SYNARRAY_CS   = cs;
  assign SYNARRAY_WE   = 1'b0;
  assign SYNARRAY_ADDR = cs ? {pre_q, widx_q} : 13'd0;
  assign SYN_VALID     = vld;
  assign SYN_PRE_ADDR  = pre_q;
  assign SYN_POST_ADDR = {widx_q, lane_q};
  assign SYN_WEIGHT    = vld ? nib[2:0] : 3'd0;
  assign ROW_DONE      = done;
  assign BUSY          = (state != IDLE);

endmodule

// File: tb/tb_synarray_row_reader.sv
// Directed bench for synarray_row_reader with an SRAM model
// and a negedge monitor logging CS, beats and ROW_DONE per cycle.
module tb_synarray_row_reader;

  logic        clk;
  logic        rst;
  logic        gate;
  logic        evt_valid;
  logic [9:0]  evt_pre;
  logic        evt_ready;
  logic        cs;
  logic        we;
  logic [12:0] addr;
  logic [31:0] rdata;
  logic        syn_valid;
  logic        syn_ready;
  logic [9:0]  syn_pre;
  logic [5:0]  syn_post;
  logic [2:0]  syn_wt;
  logic        row_done;
  logic        busy;

  synarray_row_reader dut (
    .CLK                    (clk),
    .RST                    (rst),
    .SPI_GATE_ACTIVITY_sync (gate),
    .EVT_VALID              (evt_valid),
    .EVT_PRE_ADDR           (evt_pre),
    .EVT_READY              (evt_ready),
    .SYNARRAY_CS            (cs),
    .SYNARRAY_WE            (we),
    .SYNARRAY_ADDR          (addr),
    .SYNARRAY_RDATA         (rdata),
    .SYN_VALID              (syn_valid),
    .SYN_READY              (syn_ready),
    .SYN_PRE_ADDR           (syn_pre),
    .SYN_POST_ADDR          (syn_post),
    .SYN_WEIGHT             (syn_wt),
    .ROW_DONE               (row_done),
    .BUSY                   (busy)
  );

  logic [31:0] mem [0:8191];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (cs) rdata <= mem[addr];

  int n_chk;
  int n_fail;
  int cyc;
  int t_acc;
  int n_acc;
  int n_stall;
  int n_we;
  int cs_cyc[$];
  int cs_addr[$];
  int b_cyc[$];
  int b_pre[$];
  int b_post[$];
  int b_wt[$];
  int st_post[$];
  int st_wt[$];
  int done_cyc[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      n_acc++;
      t_acc = cyc;
    end
    if (we) n_we++;
    if (cs) begin
      cs_cyc.push_back(cyc);
      cs_addr.push_back(int'(addr));
    end
    if (syn_valid && syn_ready) begin
      b_cyc.push_back(cyc);
      b_pre.push_back(int'(syn_pre));
      b_post.push_back(int'(syn_post));
      b_wt.push_back(int'(syn_wt));
    end
    if (syn_valid && !syn_ready) begin
      n_stall++;
      st_post.push_back(int'(syn_post));
      st_wt.push_back(int'(syn_wt));
    end
    if (row_done) done_cyc.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_log();
    t_acc = -1;
    n_acc = 0;
    n_stall = 0;
    cs_cyc.delete();
    cs_addr.delete();
    b_cyc.delete();
    b_pre.delete();
    b_post.delete();
    b_wt.delete();
    st_post.delete();
    st_wt.delete();
    done_cyc.delete();
  endtask

  task automatic send(input logic [9:0] pre);
    clear_log();
    step();
    evt_pre = pre;
    evt_valid = 1'b1;
    for (int i = 0; i < 20 && t_acc < 0; i++) step();
    evt_valid = 1'b0;
    check("accept", t_acc >= 0, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_cyc.size() == 0; i++) step();
    check("done_seen", done_cyc.size(), 1);
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 300 && cyc < c; i++) step();
  endtask

  task automatic check_full(input int pre, input int lat);
    check("beat_cnt", b_cyc.size(), 64);
    for (int i = 0; i < b_cyc.size(); i++) begin
      check("beat_post", b_post[i], i);
      check("beat_wt", b_wt[i], i % 8);
      check("beat_pre", b_pre[i], pre);
    end
    if (b_cyc.size() == 64) begin
      check("last_beat_cyc", b_cyc[63] - t_acc, lat - 1);
    end
    if (done_cyc.size() > 0) check("done_cyc", done_cyc[0] - t_acc, lat);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    n_we = 0;
    clear_log();
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      mem[13'h028 + i] = 32'hFEDC_BA98;
      mem[13'h1FF8 + i] = 32'hFEDC_BA98;
    end
    mem[13'h048] = 32'h0000_00F7;
    rst = 1'b1;
    gate = 1'b0;
    evt_valid = 1'b0;
    evt_pre = '0;
    syn_ready = 1'b1;

    // reset state
    step();
    step();
    @(negedge clk);
    check("rst_evt_ready", evt_ready, 0);
    check("rst_cs", cs, 0);
    check("rst_addr", addr, 0);
    check("rst_syn_valid", syn_valid, 0);
    check("rst_syn_pre", syn_pre, 0);
    check("rst_syn_post", syn_post, 0);
    check("rst_syn_wt", syn_wt, 0);
    check("rst_row_done", row_done, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    check("idle_evt_ready", evt_ready, 1);

    // full mapped row, pre 0x005
    send(10'h005);
    wait_done();
    @(negedge clk);
    check("ready_after_row", evt_ready, 1);
    check("busy_after_row", busy, 0);
    check("cs_cnt", cs_cyc.size(), 8);
    for (int i = 0; i < cs_cyc.size(); i++) begin
      check("cs_addr", cs_addr[i], 32'h28 + i);
      check("cs_cyc", cs_cyc[i] - t_acc, 1 + 10 * i);
    end
    if (b_cyc.size() > 0) check("first_beat_cyc", b_cyc[0] - t_acc, 3);
    check_full(5, 81);

    // sparse row, event ignored while busy
    send(10'h009);
    wait_until(t_acc + 5);
    evt_valid = 1'b1;
    evt_pre = 10'h123;
    wait_until(t_acc + 10);
    @(negedge clk);
    check("busy_evt_ready", evt_ready, 0);
    evt_valid = 1'b0;
    wait_done();
    check("sparse_beats", b_cyc.size(), 1);
    if (b_cyc.size() > 0) begin
      check("sparse_post", b_post[0], 1);
      check("sparse_wt", b_wt[0], 7);
      check("sparse_pre", b_pre[0], 9);
    end
    if (done_cyc.size() > 0) check("sparse_done", done_cyc[0] - t_acc, 81);
    check("single_accept", n_acc, 1);

    // downstream stall on first beat
    syn_ready = 1'b0;
    send(10'h005);
    wait_until(t_acc + 8);
    syn_ready = 1'b1;
    wait_done();
    check("stall_cycles", n_stall, 5);
    for (int i = 0; i < st_post.size(); i++) begin
      check("stall_post", st_post[i], 0);
      check("stall_wt", st_wt[i], 0);
    end
    if (b_cyc.size() > 0) check("stall_first_beat", b_cyc[0] - t_acc, 8);
    check_full(5, 86);

    // gate in idle, then gate raised mid-row
    step();
    gate = 1'b1;
    clear_log();
    evt_pre = 10'h005;
    evt_valid = 1'b1;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    check("gated_evt_ready", evt_ready, 0);
    check("gated_busy", busy, 0);
    check("gated_no_accept", n_acc, 0);
    evt_valid = 1'b0;
    gate = 1'b0;
    send(10'h005);
    wait_until(t_acc + 20);
    gate = 1'b1;
    wait_done();
    check_full(5, 81);
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    check("gated_after_row", evt_ready, 0);
    check("gated_after_busy", busy, 0);
    gate = 1'b0;

    // reset mid-row
    send(10'h005);
    wait_until(t_acc + 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_syn_valid", syn_valid, 0);
    check("abort_cs", cs, 0);
    check("abort_busy", busy, 0);
    check("abort_cyc", cyc - t_acc, 21);
    for (int i = 0; i < 100; i++) step();
    check("abort_no_done", done_cyc.size(), 0);
    send(10'h005);
    wait_done();
    check_full(5, 81);

    // top pre address
    send(10'h3FF);
    wait_done();
    check("top_cs_cnt", cs_cyc.size(), 8);
    for (int i = 0; i < cs_cyc.size(); i++) begin
      check("top_cs_addr", cs_addr[i], 32'h1FF8 + i);
    end
    check_full(10'h3FF, 81);
    check("we_never", n_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/synarray_row_reader.md
SYNARRAY_ROW_READER -- requirements
Module: synarray_row_reader

Interface
REQ-001 SHALL have parameter SKIP_UNMAPPED, default 1; 1 = suppress synapses whose mapped bit is 0, 0 = emit all lanes.
REQ-002 SHALL have parameter WORDS_PER_ROW, default 8; 32-bit words per pre-neuron row (fixed 8, 3-bit word index).
REQ-003 SHALL have port CLK  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port SPI_GATE_ACTIVITY_sync  input  1  when high, no new row accepted.
REQ-006 SHALL have port EVT_VALID  input  1  pre-neuron spike event present.
REQ-007 SHALL have port EVT_PRE_ADDR  input  10  pre-neuron address of event.
REQ-008 SHALL have port EVT_READY  output  1  event accepted on EVT_VALID&EVT_READY.
REQ-009 SHALL have port SYNARRAY_CS  output  1  SRAM chip select (read).
REQ-010 SHALL have port SYNARRAY_WE  output  1  SRAM write enable, constant 0.
REQ-011 SHALL have port SYNARRAY_ADDR  output  13  SRAM word address.
REQ-012 SHALL have port SYNARRAY_RDATA  input  32  SRAM read data, valid one cycle after CS.
REQ-013 SHALL have port SYN_VALID  output  1  synapse beat valid.
REQ-014 SHALL have port SYN_READY  input  1  downstream accepts beat.
REQ-015 SHALL have port SYN_PRE_ADDR  output  10  pre address of current row.
REQ-016 SHALL have port SYN_POST_ADDR  output  6  post-neuron index {word_idx, lane}.
REQ-017 SHALL have port SYN_WEIGHT  output  3  weight, nibble bits [2:0].
REQ-018 SHALL have port ROW_DONE  output  1  one-cycle pulse at row completion.
REQ-019 SHALL have port BUSY  output  1  high in any state except IDLE.

Function
REQ-020 SHALL implement FSM IDLE, READ, WAIT, UNPACK, DONE.
REQ-021 IDLE: EVT_READY = ~SPI_GATE_ACTIVITY_sync; on accept, latch EVT_PRE_ADDR, word_idx=0, lane=0; go READ.
REQ-022 READ: SYNARRAY_CS=1 for exactly one cycle, SYNARRAY_ADDR={pre_addr, word_idx}; go WAIT.
REQ-023 WAIT: capture SYNARRAY_RDATA into word register; go UNPACK.
REQ-024 UNPACK: lane L nibble = word[4L+3:4L]; bit 3 = mapped, bits [2:0] = weight.
REQ-025 UNPACK: SYN_VALID=1 iff nibble mapped or SKIP_UNMAPPED=0; lane advances on SYN_VALID&SYN_READY, or in one cycle when lane suppressed.
REQ-026 SYN_VALID, SYN_POST_ADDR, SYN_WEIGHT, SYN_PRE_ADDR SHALL stay stable while SYN_VALID&~SYN_READY.
REQ-027 After lane 7 advances: word_idx<7 -> word_idx+1, lane=0, READ; word_idx==7 -> DONE.
REQ-028 DONE: ROW_DONE=1 one cycle, EVT_READY=0; go IDLE.
REQ-029 Latency: accept at cycle T -> CS at T+1, first beat earliest T+3; full mapped row, SYN_READY=1: last beat T+80, ROW_DONE T+81, EVT_READY T+82.
REQ-030 SPI_GATE_ACTIVITY_sync rising mid-row SHALL NOT abort; row completes, then EVT_READY held low while gated.
REQ-031 EVT_VALID outside IDLE SHALL be ignored (not queued).
REQ-032 Word-index increment SHALL NOT wrap into next pre row; address upper bits fixed for whole row.

Reset
REQ-033 RST high SHALL force IDLE next edge, any state, including mid-row; no ROW_DONE for aborted row.
REQ-034 Reset values: EVT_READY=0 during RST, SYNARRAY_CS=0, SYNARRAY_ADDR=0, SYN_VALID=0, SYN_PRE_ADDR=0, SYN_POST_ADDR=0, SYN_WEIGHT=0, ROW_DONE=0, BUSY=0; SYNARRAY_WE=0 always.

Verification
REQ-035 All words 0xFEDCBA98, pre 0x005, SYN_READY=1 -> 64 beats, post 0..63, weight = post[2:0], addresses 0x0028..0x002F, ROW_DONE at T+81.
REQ-036 Word 0 = 0x000000F7, others 0, SKIP_UNMAPPED=1 -> single beat post 1 weight 7; lane 0 (0x7) suppressed; ROW_DONE still issued.
REQ-037 SYN_READY low 5 cycles on first beat -> beat held stable 5 cycles, no lost/duplicated beats, ROW_DONE delayed by 5.
REQ-038 Gate high in IDLE -> EVT_READY=0, EVT_VALID ignored; gate raised at T+20 -> row completes, ROW_DONE T+81, EVT_READY stays 0.
REQ-039 RST pulsed at T+20 -> T+21 IDLE, SYN_VALID=0, CS=0, BUSY=0, no ROW_DONE; new event accepted normally.
REQ-040 Pre 0x3FF -> CS pulses at addresses 0x1FF8..0x1FFF in order, one per word.
